// File: rtl/reg_file_pkg.sv
// Shared register-file geometry for the processor datapath and the register file.
// The display-half encoding is used by the board-level readout mux.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned DISP_W   = DATA_W / 2;

  typedef enum logic {
    HALF_LO = 1'b0,
    HALF_HI = 1'b1
  } disp_half_e;

endpackage

// File: rtl/reg_file.sv
// 32 x 32 register file: r0 hardwired to zero, two combinational read ports,
// one synchronous write port, and a 16-bit half-word display readout of r0..r15.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W = reg_file_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_file_pkg::ADDR_W,
  parameter int unsigned DISP_W = reg_file_pkg::DISP_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW0,
  input  logic              SW1,
  input  logic              SW2,
  input  logic              btnL,
  input  logic              btnR,
  input  logic              regw,
  input  logic [ADDR_W-1:0] dr,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  input  logic [DATA_W-1:0] reg_in,
  output logic [DATA_W-1:0] readreg1,
  output logic [DATA_W-1:0] readreg2,
  output logic [DISP_W-1:0] readreg
);

  localparam int unsigned N_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [N_REGS];
  logic [ADDR_W-1:0] w_disp_idx;
  logic [DATA_W-1:0] w_disp_reg;
  disp_half_e        w_half;

  // Reset wins over a simultaneous write; index 0 is never loaded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (regw && (dr != '0)) begin
      r_regs[dr] <= reg_in;
    end
  end

  // No write bypass: reads always see the stored value, so a same-cycle
  // write to a read index shows up only after the clock edge.
  always_comb begin
    readreg1 = (sr1 == '0) ? '0 : r_regs[sr1];
    readreg2 = (sr2 == '0) ? '0 : r_regs[sr2];
  end

  assign w_disp_idx = {{(ADDR_W-4){1'b0}}, btnR, SW2, SW1, SW0};
  assign w_half     = disp_half_e'(btnL);

  always_comb begin
    w_disp_reg = (w_disp_idx == '0) ? '0 : r_regs[w_disp_idx];
    readreg    = '0;
    unique case (w_half)
      HALF_HI: readreg = w_disp_reg[DATA_W-1:DISP_W];
      HALF_LO: readreg = w_disp_reg[DISP_W-1:0];
    endcase
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic checked against an array model of the 32 registers.
module tb_reg_file;

  logic        CLK;
  logic        RST;
  logic        SW0, SW1, SW2, btnL, btnR, regw;
  logic [4:0]  dr, sr1, sr2;
  logic [31:0] reg_in;
  logic [31:0] readreg1, readreg2;
  logic [15:0] readreg;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [31:0] model [32];

  reg_file #(.DATA_W(32), .ADDR_W(5), .DISP_W(16)) dut (
    .CLK(CLK), .RST(RST), .SW0(SW0), .SW1(SW1), .SW2(SW2),
    .btnL(btnL), .btnR(btnR), .regw(regw), .dr(dr), .sr1(sr1), .sr2(sr2),
    .reg_in(reg_in), .readreg1(readreg1), .readreg2(readreg2), .readreg(readreg)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_disp();
    int idx;
    logic [31:0] v;
    idx = (btnR ? 8 : 0) + (SW2 ? 4 : 0) + (SW1 ? 2 : 0) + (SW0 ? 1 : 0);
    v = model[idx];
    return btnL ? (v >> 16) : (v & 32'h0000_FFFF);
  endfunction

  task automatic check_reads(input string tag);
    check({tag, ".rd1"}, readreg1, model[sr1]);
    check({tag, ".rd2"}, readreg2, model[sr2]);
    check({tag, ".disp"}, {16'h0, readreg}, exp_disp());
  endtask

  // Inputs are already applied; check reads before the edge, then clock and update the model.
  task automatic step(input string tag);
    #2;
    check_reads({tag, ".pre"});
    @(posedge CLK);
    if (RST) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (regw && dr != 0) begin
      model[dr] = reg_in;
    end
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    regw = 1'b1; dr = a; reg_in = d;
    step("wr");
    regw = 1'b0;
  endtask

  task automatic set_disp(input logic r, input logic [2:0] sw, input logic l);
    btnR = r; {SW2, SW1, SW0} = sw; btnL = l;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    RST = 1'b1; regw = 1'b0; dr = '0; sr1 = '0; sr2 = '0; reg_in = '0;
    set_disp(1'b0, 3'b000, 1'b0);

    // Reset clears everything
    @(posedge CLK); #1;
    RST = 1'b0;
    sr1 = 5'd5; sr2 = 5'd31; set_disp(1'b1, 3'b001, 1'b0);
    #1;
    check("rst.rd1", readreg1, 32'h0);
    check("rst.rd2", readreg2, 32'h0);
    check("rst.disp", {16'h0, readreg}, 32'h0);

    // Write/read with old value during write cycle
    sr1 = 5'd3; regw = 1'b1; dr = 5'd3; reg_in = 32'hDEADBEEF;
    #1;
    check("wr.old", readreg1, 32'h0);
    step("wr3");
    regw = 1'b0; #1;
    check("wr.new", readreg1, 32'hDEADBEEF);

    // r0 protection
    write(5'd0, 32'hFFFFFFFF);
    sr1 = 5'd0; #1;
    check("r0.zero", readreg1, 32'h0);

    // Display halves of r10
    write(5'd10, 32'h12345678);
    set_disp(1'b1, 3'b010, 1'b0); #1;
    check("disp.lo", {16'h0, readreg}, 32'h5678);
    set_disp(1'b1, 3'b010, 1'b1); #1;
    check("disp.hi", {16'h0, readreg}, 32'h1234);

    // Dual read in the same cycle
    write(5'd7, 32'hA5A5A5A5);
    write(5'd31, 32'h0000FFFF);
    sr1 = 5'd7; sr2 = 5'd31; #1;
    check("dual.rd1", readreg1, 32'hA5A5A5A5);
    check("dual.rd2", readreg2, 32'h0000FFFF);
    sr1 = 5'd7; sr2 = 5'd7; #1;
    check("same.rd2", readreg2, 32'hA5A5A5A5);

    // Reset overrides a simultaneous write and wipes prior contents
    write(5'd4, 32'h11);
    RST = 1'b1; regw = 1'b1; dr = 5'd4; reg_in = 32'h55;
    step("rstwr");
    RST = 1'b0; regw = 1'b0;
    sr1 = 5'd4; sr2 = 5'd7; set_disp(1'b1, 3'b010, 1'b1); #1;
    check("rstpri.r4", readreg1, 32'h0);
    check("rstpri.r7", readreg2, 32'h0);
    check("rstpri.disp", {16'h0, readreg}, 32'h0);

    // Random traffic, biased toward reading the register being written
    for (int n = 0; n < 400; n++) begin
      RST    = ($urandom_range(0, 39) == 0);
      regw   = $urandom_range(0, 2) != 0;
      dr     = 5'($urandom_range(0, 31));
      reg_in = $urandom;
      sr1    = ($urandom_range(0, 3) == 0) ? dr : 5'($urandom_range(0, 31));
      sr2    = 5'($urandom_range(0, 31));
      set_disp(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      step("rnd");
      check_reads("rnd.post");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
